// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the RamD port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    typedef logic port_id_t;

    localparam int unsigned DEPTH_DEFAULT  = 328;
    localparam int unsigned RD_LAT_DEFAULT = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake plus the RamD connection, bundled for the arbiter.
interface ram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]    req_i;
    logic [1:0]    we_i;
    logic [AW-1:0] addr0_i;
    logic [AW-1:0] addr1_i;
    logic [DW-1:0] wdata0_i;
    logic [DW-1:0] wdata1_i;
    logic [1:0]    gnt_o;
    logic          rsp_valid_o;
    logic          rsp_id_o;
    logic          rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          busy_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic          ram_wren_o;
    logic [DW-1:0] ram_q_i;

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_q_i,
        input  gnt_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_rdata_o, busy_o,
               ram_addr_o, ram_data_o, ram_wren_o
    );

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_q_i,
        output gnt_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_rdata_o, busy_o,
               ram_addr_o, ram_data_o, ram_wren_o
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; the pointer remembers the last granted port.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    input  port_id_t   adv_id,
    output port_id_t   pick
);

    port_id_t last;

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (adv) begin
            last <= adv_id;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares single-port RamD between the CPU LSU (port 0) and the loader (port 1),
// sequencing each access and returning the response tagged with its owner.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned RD_LAT = RD_LAT_DEFAULT,
    parameter int          AW     = 32,
    parameter int          DW     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    state_t        state;
    port_id_t      id;
    logic          we;
    logic          inr;
    logic [1:0]    cnt;
    logic [1:0]    gnt;
    logic          rsp_valid;
    logic          rsp_id;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;

    port_id_t      pick;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;
    logic          pick_we;
    logic          pick_inr;

    function automatic logic in_range(input logic [AW-1:0] a);
        return a < AW'(DEPTH);
    endfunction

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req_i),
        .adv    (state == ACCESS),
        .adv_id (id),
        .pick   (pick)
    );

    assign pick_addr  = pick ? bus.addr1_i  : bus.addr0_i;
    assign pick_wdata = pick ? bus.wdata1_i : bus.wdata0_i;
    assign pick_we    = bus.we_i[pick];
    assign pick_inr   = in_range(pick_addr);

    // Outputs are loaded on the edge entering each state so they are valid
    // for exactly the cycle the FSM spends there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            id        <= 1'b0;
            we        <= 1'b0;
            inr       <= 1'b0;
            cnt       <= 2'd0;
            gnt       <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_wren  <= 1'b0;
        end else begin
            gnt       <= 2'b00;
            rsp_valid <= 1'b0;
            ram_wren  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        id       <= pick;
                        we       <= pick_we;
                        inr      <= pick_inr;
                        gnt      <= pick ? 2'b10 : 2'b01;
                        ram_addr <= pick_addr;
                        ram_data <= pick_wdata;
                        ram_wren <= pick_we & pick_inr;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we || !inr) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                        rsp_err   <= !inr;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        cnt   <= 2'd1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'(RD_LAT)) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= bus.ram_q_i;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_id_o    = rsp_id;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.busy_o      = busy;
    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_data_o  = ram_data;
    assign bus.ram_wren_o  = ram_wren;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port data RAM (RamD: 32-bit address, 32-bit data, wren, registered q) between two requesters: port 0 is the CPU load/store unit and port 1 is the loader/display engine. The block runs round-robin arbitration and checks addresses against the RAM depth. It sequences each access (address/write phase, read-latency wait, response) and returns the result with the id of the requester that made it. It sits between the requesters and the RamD instance and drives all RamD inputs.

Parameters:
DEPTH, 328, number of 32-bit words in RamD; word addresses >= DEPTH are out of range.
RD_LAT, 1, RamD read latency in cycles from the address-sampling edge to q valid (legal range 1..3).
AW, 32, address width on requester and RAM side.
DW, 32, data width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
req_i  in  2  per-port request; bit p is port p.
we_i  in  2  per-port write enable, qualified by req_i.
addr0_i  in  AW  port 0 word address.
addr1_i  in  AW  port 1 word address.
wdata0_i  in  DW  port 0 write data.
wdata1_i  in  DW  port 1 write data.
gnt_o  out  2  one-hot grant; high for exactly one cycle (the ACCESS cycle).
rsp_valid_o  out  1  one-cycle response pulse (read data or write completion).
rsp_id_o  out  1  port that owns the response.
rsp_err_o  out  1  out-of-range address; qualified by rsp_valid_o.
rsp_rdata_o  out  DW  read data; 0 for writes and errors.
busy_o  out  1  high in any state other than IDLE.
ram_addr_o  out  AW  to RamD address.
ram_data_o  out  DW  to RamD data.
ram_wren_o  out  1  to RamD wren.
ram_q_i  in  DW  from RamD q.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - gnt_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o, ram_wren_o go to 0; rsp_rdata_o, ram_addr_o, ram_data_o go to 0.
  - The round-robin pointer is set so port 0 wins the first tie.
  - Reset mid-access aborts the access. ram_wren_o is low from the first reset cycle onward, and no response is produced.
- IDLE, with any req_i bit set:
  - Pick the winner:
    - Single requester: that port wins.
    - Both requesting: the port not granted last wins.
  - Latch the winner's id, we, addr and wdata, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (1 cycle):
  - gnt_o[id]=1.
  - ram_addr_o = latched addr.
  - ram_data_o = latched wdata.
  - ram_wren_o = we AND in_range.
  - Update the round-robin pointer.
  - Write or error: go to RESP. Read in range: go to WAIT.
- WAIT:
  - Counter runs 1..RD_LAT. ram_addr_o is held and ram_wren_o=0.
  - In the cycle where counter==RD_LAT, capture ram_q_i into the data register and go to RESP.
- RESP (1 cycle):
  - rsp_valid_o=1 with rsp_id_o=id.
  - rsp_err_o = !in_range.
  - rsp_rdata_o = captured data for a good read, else 0.
  - Next state is IDLE.
- Latency, counted from the request-sampling edge (cycle 0 = IDLE):
  - gnt_o in cycle 1.
  - Write or error response in cycle 2.
  - Read response in cycle 2+RD_LAT.
- Handshake:
  - A requester holds req and its fields stable until it sees its gnt_o bit.
  - A requester deasserts req in the cycle after gnt, unless it wants a new access.
  - Requests are not sampled in ACCESS, WAIT or RESP. A request still held there is re-arbitrated in the next IDLE.
- in_range = (addr < DEPTH), as an unsigned AW-bit compare. Address DEPTH-1 is legal; DEPTH and 32'hFFFFFFFF give an error. An out-of-range write never asserts ram_wren_o.
- Outside ACCESS and WAIT, ram_addr_o and ram_data_o hold their last values and ram_wren_o=0.
- Simultaneous requests alternate strictly: 0,1,0,1... This holds even if one port's request falls and re-rises between grants.

Decomposition:
- Package ram_arb_pkg holds:
  - state_t enum {IDLE, ACCESS, WAIT, RESP};
  - port_id_t (1 bit);
  - default DEPTH=328 and RD_LAT=1 constants.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req and last-grant, plus the pointer register with enable. The pointer advances only in ACCESS.

Test Plan:
- Reset for 3 cycles, then idle -> all outputs 0 and busy_o=0.
- Port 0 writes 32'hDEADBEEF to addr 3 at edge 0 -> gnt_o=2'b01 in cycle 1 with ram_wren_o=1 and ram_addr_o=3; rsp_valid_o=1, rsp_id_o=0, rsp_err_o=0 in cycle 2. Port 1 then reads addr 3 -> rsp_rdata_o=32'hDEADBEEF at cycle 2+RD_LAT (cycle 3 for RD_LAT=1), rsp_id_o=1.
- Both ports request reads of addrs 9 and 17 continuously -> grants alternate 01,10,01,10 with the first grant to port 0; each response carries the matching rsp_id_o and data.
- Port 1 writes to addr 328, then addr 32'hFFFFFFFF -> ram_wren_o never 1, rsp_err_o=1, rsp_rdata_o=0. A write to addr 327 succeeds with rsp_err_o=0.
- Assert rst_n low during WAIT of a read of addr 0 -> no rsp_valid_o pulse, IDLE the next cycle, outputs at reset values. A subsequent request from both ports grants port 0 first.
- RD_LAT=3 build: read of addr 17 -> rsp_valid_o exactly in cycle 5 after the sampling edge, busy_o high in cycles 1-5.
